// File: rtl/num_dots_multi_pkg.sv
// Shared types and 5x7 glyph table for the multi-digit dot-matrix number decoder.
// Glyph layout: 5 column bytes, left column in the most significant byte, bit 7 unused.
package num_dots_pkg;

    localparam int unsigned GLYPH_W = 40;
    localparam int unsigned BCD_W   = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NEGATE  = 3'd1,
        CONVERT = 3'd2,
        RENDER  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [GLYPH_W-1:0] GLYPH_0     = 40'h3E_51_49_45_3E;
    localparam logic [GLYPH_W-1:0] GLYPH_1     = 40'h00_42_7F_40_00;
    localparam logic [GLYPH_W-1:0] GLYPH_2     = 40'h42_61_51_49_46;
    localparam logic [GLYPH_W-1:0] GLYPH_3     = 40'h21_41_45_4B_31;
    localparam logic [GLYPH_W-1:0] GLYPH_4     = 40'h18_14_12_7F_10;
    localparam logic [GLYPH_W-1:0] GLYPH_5     = 40'h27_45_45_45_39;
    localparam logic [GLYPH_W-1:0] GLYPH_6     = 40'h3C_4A_49_49_30;
    localparam logic [GLYPH_W-1:0] GLYPH_7     = 40'h01_71_09_05_03;
    localparam logic [GLYPH_W-1:0] GLYPH_8     = 40'h36_49_49_49_36;
    localparam logic [GLYPH_W-1:0] GLYPH_9     = 40'h06_49_49_29_1E;
    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 40'h00_00_00_00_00;
    localparam logic [GLYPH_W-1:0] GLYPH_DASH  = 40'h08_08_08_08_08;

endpackage

// File: rtl/num_dots_multi_if.sv
// Start/busy/done handshake plus value and bitmap bus of the number-to-dots converter.
interface num_dots_multi_if
    import num_dots_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
);
    logic                        start;
    logic [WIDTH-1:0]            num;
    logic                        busy;
    logic                        done;
    logic                        overflow;
    logic [DIGITS*GLYPH_W-1:0]   dots;

    modport master (output start, output num, input busy, input done, input overflow, input dots);
    modport slave  (input start, input num, output busy, output done, output overflow, output dots);
endinterface

// File: rtl/num_dots_multi_digit_glyph.sv
// One BCD digit to its 5x7 bitmap; dash takes priority over blank, non-decimal codes render blank.
module digit_glyph
    import num_dots_pkg::*;
(
    input  logic [BCD_W-1:0]   bcd,
    input  logic               blank,
    input  logic               dash,
    output logic [GLYPH_W-1:0] glyph_c
);

    always_comb begin
        glyph_c = GLYPH_BLANK;
        if (dash) begin
            glyph_c = GLYPH_DASH;
        end else if (!blank) begin
            case (bcd)
                4'd0:    glyph_c = GLYPH_0;
                4'd1:    glyph_c = GLYPH_1;
                4'd2:    glyph_c = GLYPH_2;
                4'd3:    glyph_c = GLYPH_3;
                4'd4:    glyph_c = GLYPH_4;
                4'd5:    glyph_c = GLYPH_5;
                4'd6:    glyph_c = GLYPH_6;
                4'd7:    glyph_c = GLYPH_7;
                4'd8:    glyph_c = GLYPH_8;
                4'd9:    glyph_c = GLYPH_9;
                default: glyph_c = GLYPH_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/num_dots_multi.sv
// Binary to right-justified decimal dot-matrix glyphs via iterative double-dabble.
// Define SIGNED_DOTS_EN to treat num as two's complement with a leading minus glyph.
module num_dots_multi
    import num_dots_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    num_dots_multi_if.slave  bus
);

    localparam int unsigned BCD_BITS = DIGITS * BCD_W;
    localparam int unsigned DOTS_W   = DIGITS * GLYPH_W;
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
    localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t               state;
    logic [WIDTH-1:0]     shift_q;
    logic [BCD_BITS-1:0]  bcd_q;
    logic                 sticky_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     idx;
    logic                 seen_q;
    logic [DOTS_W-1:0]    shadow_q;
    logic [DOTS_W-1:0]    dots_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ovf_q;

    logic [BCD_BITS-1:0]  bcd_adj_c;
    logic [BCD_W-1:0]     nib_c;
    logic                 blank_c;
    logic                 dash_c;
    logic                 ovf_all_c;
    logic [GLYPH_W-1:0]   glyph_c;
    logic [DOTS_W-1:0]    shadow_next_c;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd_q[k*BCD_W +: BCD_W] >= 4'd5) begin
                bcd_adj_c[k*BCD_W +: BCD_W] = bcd_q[k*BCD_W +: BCD_W] + 4'd3;
            end
        end
    end

    assign nib_c   = bcd_q[{idx, 2'b00} +: BCD_W];
    // Leading zeros blank while walking downward; the units digit always shows.
    assign blank_c = !seen_q && (nib_c == 4'd0) && (idx != IDX_W'(0));

`ifdef SIGNED_DOTS_EN
    logic                 neg_q;
    logic [IDX_W-1:0]     idx_lo_c;
    logic [BCD_W-1:0]     nib_lo_c;

    // A negative value needs one free position above its top digit for the minus sign.
    assign idx_lo_c  = (idx == IDX_W'(0)) ? IDX_W'(0) : idx - IDX_W'(1);
    assign nib_lo_c  = bcd_q[{idx_lo_c, 2'b00} +: BCD_W];
    assign ovf_all_c = sticky_q || (neg_q && (bcd_q[BCD_BITS-1 -: BCD_W] != 4'd0));
    assign dash_c    = ovf_all_c ||
                       (neg_q && blank_c && ((nib_lo_c != 4'd0) || (idx == IDX_W'(1))));
`else
    assign ovf_all_c = sticky_q;
    assign dash_c    = sticky_q;
`endif

    digit_glyph u_glyph (
        .bcd     (nib_c),
        .blank   (blank_c),
        .dash    (dash_c),
        .glyph_c (glyph_c)
    );

    always_comb begin
        shadow_next_c = shadow_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx == IDX_W'(k)) begin
                shadow_next_c[k*GLYPH_W +: GLYPH_W] = glyph_c;
            end
        end
    end

    // Control FSM; dots and overflow load together with the done pulse so no partial result is visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            bit_cnt  <= '0;
            idx      <= '0;
            seen_q   <= 1'b0;
            shadow_q <= '0;
            dots_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SIGNED_DOTS_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_q  <= bus.num;
                        bcd_q    <= '0;
                        sticky_q <= 1'b0;
                        bit_cnt  <= '0;
                        busy_q   <= 1'b1;
`ifdef SIGNED_DOTS_EN
                        neg_q    <= bus.num[WIDTH-1];
                        state    <= NEGATE;
`else
                        state    <= CONVERT;
`endif
                    end
                end
`ifdef SIGNED_DOTS_EN
                NEGATE: begin
                    if (neg_q) begin
                        shift_q <= -shift_q;
                    end
                    state <= CONVERT;
                end
`endif
                CONVERT: begin
                    bcd_q   <= {bcd_adj_c[BCD_BITS-2:0], shift_q[WIDTH-1]};
                    shift_q <= {shift_q[WIDTH-2:0], 1'b0};
                    if (bcd_adj_c[BCD_BITS-1]) begin
                        sticky_q <= 1'b1;
                    end
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        idx    <= IDX_W'(DIGITS - 1);
                        seen_q <= 1'b0;
                        state  <= RENDER;
                    end
                end
                RENDER: begin
                    shadow_q <= shadow_next_c;
                    if (nib_c != 4'd0) begin
                        seen_q <= 1'b1;
                    end
                    idx <= idx - IDX_W'(1);
                    if (idx == IDX_W'(0)) begin
                        dots_q <= shadow_next_c;
                        ovf_q  <= ovf_all_c;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.dots     = dots_q;

endmodule

// File: tb/tb_num_dots_multi.sv
// Scoreboard bench for num_dots_multi: a 5-digit and a 4-digit instance, 16-bit input.
module tb_num_dots_multi;

    localparam int unsigned W = 16;
`ifdef SIGNED_DOTS_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif
    localparam int LAT5 = 16 + 5 + 1 + XTRA;
    localparam int LAT4 = 16 + 4 + 1 + XTRA;
    localparam logic [39:0] TB_DASH = 40'h0808080808;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    num_dots_multi_if #(.WIDTH(W), .DIGITS(5)) bus5 ();
    num_dots_multi_if #(.WIDTH(W), .DIGITS(4)) bus4 ();

    num_dots_multi #(.WIDTH(W), .DIGITS(5)) u_dut5 (.clk(clk), .reset_n(reset_n), .bus(bus5));
    num_dots_multi #(.WIDTH(W), .DIGITS(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done5    = 0;
    int done4    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [319:0] dots;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t q5[$];
    exp_t q4[$];

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] tb_glyph(input int d);
        case (d)
            0: return 40'h3E5149453E;
            1: return 40'h00427F4000;
            2: return 40'h4261514946;
            3: return 40'h2141454B31;
            4: return 40'h1814127F10;
            5: return 40'h2745454539;
            6: return 40'h3C4A494930;
            7: return 40'h0171090503;
            8: return 40'h3649494936;
            9: return 40'h064949291E;
            default: return 40'h0;
        endcase
    endfunction

    // Reference: decimal digits by division, blanking and sign placement by digit count.
    task automatic model(input logic [15:0] n, input int nd, output logic [319:0] d, output logic ov);
        int unsigned mag;
        int unsigned t;
        int          dig[8];
        int          sig;
        int          neg;
        neg = 0;
        mag = 32'(n);
`ifdef SIGNED_DOTS_EN
        if (n[15]) begin
            neg = 1;
            mag = 32'd65536 - 32'(n);
        end
`endif
        t = mag;
        for (int k = 0; k < 8; k++) begin
            dig[k] = int'(t % 10);
            t      = t / 10;
        end
        sig = 1;
        for (int k = 1; k < 8; k++) if (dig[k] != 0) sig = k + 1;
        ov = ((sig + neg) > nd);
        d  = '0;
        for (int k = 0; k < nd; k++) begin
            if (ov)                      d[k*40 +: 40] = TB_DASH;
            else if (k < sig)            d[k*40 +: 40] = tb_glyph(dig[k]);
            else if (neg == 1 && k == sig) d[k*40 +: 40] = TB_DASH;
        end
    endtask

    task automatic push5(input logic [15:0] n, input int c);
        exp_t e;
        model(n, 5, e.dots, e.ov);
        e.cyc = c + LAT5;
        q5.push_back(e);
    endtask

    task automatic push4(input logic [15:0] n, input int c);
        exp_t e;
        model(n, 4, e.dots, e.ov);
        e.cyc = c + LAT4;
        q4.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus5.done === 1'b1) begin
            exp_t e;
            done5++;
            check("busy_with_done5", 320'(bus5.busy), 320'(0));
            checks++;
            assert (q5.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_done5 observed_queue=%0d expected_nonempty", q5.size());
            end
            if (q5.size() != 0) begin
                e = q5.pop_front();
                check("dots5", 320'(bus5.dots), e.dots);
                check("overflow5", 320'(bus5.overflow), 320'(e.ov));
                check("latency5", 320'(cyc), 320'(e.cyc));
            end
        end
        if (bus4.done === 1'b1) begin
            exp_t e;
            done4++;
            checks++;
            assert (q4.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_done4 observed_queue=%0d expected_nonempty", q4.size());
            end
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("dots4", 320'(bus4.dots), e.dots);
                check("overflow4", 320'(bus4.overflow), 320'(e.ov));
                check("latency4", 320'(cyc), 320'(e.cyc));
            end
        end
    end

    task automatic start5(input logic [15:0] n, input bit expect_done);
        @(negedge clk);
        bus5.start = 1'b1;
        bus5.num   = n;
        if (expect_done) push5(n, cyc);
        @(negedge clk);
        bus5.start = 1'b0;
    endtask

    task automatic start4(input logic [15:0] n);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.num   = n;
        push4(n, cyc);
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    task automatic wait5(input int target);
        int n = 0;
        while (done5 < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        assert (done5 >= target) else begin
            failures++;
            $error("FAIL timeout5 observed_dones=%0d expected=%0d", done5, target);
        end
    endtask

    task automatic wait4(input int target);
        int n = 0;
        while (done4 < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        assert (done4 >= target) else begin
            failures++;
            $error("FAIL timeout4 observed_dones=%0d expected=%0d", done4, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        bus5.start = 1'b0;
        bus5.num   = '0;
        bus4.start = 1'b0;
        bus4.num   = '0;
        repeat (3) @(negedge clk);
        check("rst_dots5", 320'(bus5.dots), 320'(0));
        check("rst_busy5", 320'(bus5.busy), 320'(0));
        check("rst_done5", 320'(bus5.done), 320'(0));
        check("rst_ovf5",  320'(bus5.overflow), 320'(0));
        check("rst_dots4", 320'(bus4.dots), 320'(0));
        reset_n = 1'b1;

        // Zero, then busy one cycle after acceptance.
        start5(16'd0, 1'b1);
        check("busy_after_start", 320'(bus5.busy), 320'(1));
        wait5(1);
        start5(16'd65535, 1'b1);  wait5(2);
        start5(16'd1234, 1'b1);   wait5(3);
        start5(16'hFFF1, 1'b1);   wait5(4);
        start5(16'h8000, 1'b1);   wait5(5);
        start5(16'd987, 1'b1);    wait5(6);

        // Four-digit instance: overflow, held, then cleared by the next conversion.
        start4(16'd12345);
        wait4(1);
        repeat (5) @(negedge clk);
        check("ovf4_held", 320'(bus4.overflow), 320'(1));
        start4(16'd7);
        wait4(2);

        // Start held with changing num: first cycle and the cycle after done are accepted.
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            bus5.start = 1'b1;
            bus5.num   = 16'(9870 + i * 7);
            if (i == 0 || i == 23) push5(bus5.num, cyc);
            @(negedge clk);
        end
        bus5.start = 1'b0;
        wait5(8);

        // Reset during CONVERT aborts without done.
        start5(16'd555, 1'b0);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_dots5", 320'(bus5.dots), 320'(0));
        check("midrst_busy5", 320'(bus5.busy), 320'(0));
        check("midrst_ovf5",  320'(bus5.overflow), 320'(0));
        check("midrst_dots4", 320'(bus4.dots), 320'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("no_done_after_abort", 320'(done5), 320'(8));
        check("dots_still_clear", 320'(bus5.dots), 320'(0));
        start5(16'd40321, 1'b1);
        wait5(9);

        repeat (3) @(negedge clk);
        check("q5_drained", 320'(q5.size()), 320'(0));
        check("q4_drained", 320'(q4.size()), 320'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
